// File: rtl/decoder_seq_if.sv
// ---------------------------------------------------------------------------
// decoder_seq_if
// Bundles the control inputs and registered outputs of decoder_seq.
//   en    : enable; low blanks the decode output
//   mode  : 0 = DIRECT (decode i), 1 = SCAN (decode internal counter)
//   i     : select index used in DIRECT mode
//   last  : highest index visited in SCAN mode
//   d     : registered one-hot (or one-cold) decode, 2^N bits
//   idx   : index currently driven on d
//   wrap  : one-cycle pulse issued with the final index of a scan pass
// Modports: master drives the controls, slave is the decoder side.
// ---------------------------------------------------------------------------
interface decoder_seq_if #(
    parameter int N = 3
);
    logic                en;
    logic                mode;
    logic [N-1:0]        i;
    logic [N-1:0]        last;
    logic [(1 << N)-1:0] d;
    logic [N-1:0]        idx;
    logic                wrap;

    modport master (
        output en, mode, i, last,
        input  d, idx, wrap
    );

    modport slave (
        input  en, mode, i, last,
        output d, idx, wrap
    );
endinterface

// File: rtl/decoder_seq.sv
// ---------------------------------------------------------------------------
// decoder_seq
// Registered N-to-2^N decoder with selectable polarity and a scan mode that
// walks the active line from 0 up to bus.last and wraps. Every output comes
// from a flop, so selects driven from here are glitch-free.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : decoder_seq_if.slave (en, mode, i, last in; d, idx, wrap out)
// Parameters:
//   N          : select width, output width is 2^N (N >= 1)
//   ACTIVE_LOW : 0 = selected line high, 1 = selected line low
// ---------------------------------------------------------------------------
module decoder_seq #(
    parameter int N          = 3,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    decoder_seq_if.slave  bus
);
    localparam int           W        = 1 << N;
    localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] INACTIVE = {W{ACTIVE_LOW}};
    localparam logic [N-1:0] TOP      = {N{1'b1}};

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // Registered state
    logic [W-1:0] d_q;
    logic [N-1:0] idx_q;
    logic         wrap_q;
    logic [N-1:0] cnt_q;
    mode_e        prev_mode_q;

    // Next-state values
    logic [W-1:0] d_nxt;
    logic [N-1:0] idx_nxt;
    logic         wrap_nxt;
    logic [N-1:0] cnt_nxt;
    mode_e        prev_mode_nxt;
    logic [N-1:0] scan_sel;

    // Entering SCAN from DIRECT always starts the pass at index 0.
    assign scan_sel = (prev_mode_q == MODE_SCAN) ? cnt_q : '0;

    always_comb begin
        // NOTE: every signal gets a default before any branch so that no
        // path leaves it unassigned; otherwise a latch is inferred.
        d_nxt         = INACTIVE;
        idx_nxt       = idx_q;
        wrap_nxt      = 1'b0;
        cnt_nxt       = cnt_q;
        prev_mode_nxt = prev_mode_q;

        if (bus.en) begin
            prev_mode_nxt = mode_e'(bus.mode);
            if (mode_e'(bus.mode) == MODE_DIRECT) begin
                d_nxt   = (ONE << bus.i) ^ INACTIVE;
                idx_nxt = bus.i;
                cnt_nxt = '0;
            end else begin
                d_nxt   = (ONE << scan_sel) ^ INACTIVE;
                idx_nxt = scan_sel;
                // Stopping at TOP as well as at last keeps the counter from
                // overflowing when last is lowered below the current count.
                if (scan_sel == bus.last || scan_sel == TOP) begin
                    cnt_nxt  = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    cnt_nxt  = scan_sel + 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q         <= INACTIVE;
            idx_q       <= '0;
            wrap_q      <= 1'b0;
            cnt_q       <= '0;
            prev_mode_q <= MODE_DIRECT;
        end else begin
            d_q         <= d_nxt;
            idx_q       <= idx_nxt;
            wrap_q      <= wrap_nxt;
            cnt_q       <= cnt_nxt;
            prev_mode_q <= prev_mode_nxt;
        end
    end

    assign bus.d    = d_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_decoder_seq.sv
// ---------------------------------------------------------------------------
// tb_decoder_seq
// Directed bench for decoder_seq. Three instances share clk/rst:
//   u0 : N=3, active-high   (reset, DIRECT, SCAN, enable gap, boundaries)
//   u1 : N=3, active-low    (polarity)
//   u2 : N=4, active-high   (full 16-line sweep)
// ---------------------------------------------------------------------------
module tb_decoder_seq;
    logic clk;
    logic rst;

    int checks;
    int errors;

    // Hand-written one-hot table for the 3-bit instance.
    logic [7:0] oh8 [8];

    decoder_seq_if #(.N(3)) bus0 ();
    decoder_seq_if #(.N(3)) bus1 ();
    decoder_seq_if #(.N(4)) bus2 ();

    decoder_seq #(.N(3), .ACTIVE_LOW(1'b0)) u0 (.clk(clk), .rst(rst), .bus(bus0));
    decoder_seq #(.N(3), .ACTIVE_LOW(1'b1)) u1 (.clk(clk), .rst(rst), .bus(bus1));
    decoder_seq #(.N(4), .ACTIVE_LOW(1'b0)) u2 (.clk(clk), .rst(rst), .bus(bus2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One checked cycle of u0 against an expected index and wrap value.
    task automatic step0(input string tag, input int exp_idx, input logic exp_wrap);
        tick();
        check({tag, "_d"},    32'(bus0.d),    32'(oh8[exp_idx]));
        check({tag, "_idx"},  32'(bus0.idx),  32'(exp_idx));
        check({tag, "_wrap"}, 32'(bus0.wrap), 32'(exp_wrap));
    endtask

    initial begin
        int scan5_idx [14];
        int resume_idx [5];
        logic resume_wrap [5];

        checks = 0;
        errors = 0;
        oh8 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        scan5_idx   = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0, 1};
        resume_idx  = '{4, 5, 6, 7, 0};
        resume_wrap = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        bus0.en = 1'b0; bus0.mode = 1'b0; bus0.i = '0; bus0.last = '0;
        bus1.en = 1'b0; bus1.mode = 1'b0; bus1.i = '0; bus1.last = '0;
        bus2.en = 1'b0; bus2.mode = 1'b0; bus2.i = '0; bus2.last = '0;

        // Reset state of all three instances
        #1;
        check("rst_d0",    32'(bus0.d),    32'h00);
        check("rst_idx0",  32'(bus0.idx),  32'h0);
        check("rst_wrap0", 32'(bus0.wrap), 32'h0);
        check("rst_d1",    32'(bus1.d),    32'hFF);
        check("rst_d2",    32'(bus2.d),    32'h0000);
        @(negedge clk);
        rst = 1'b0;

        // DIRECT sweep
        bus0.en = 1'b1;
        bus0.mode = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus0.i = 3'(k);
            step0($sformatf("direct_%0d", k), k, 1'b0);
        end

        // Asynchronous reset in the middle of a cycle, checked before any edge
        #2;
        rst = 1'b1;
        #1;
        check("arst_d",    32'(bus0.d),    32'h00);
        check("arst_idx",  32'(bus0.idx),  32'h0);
        check("arst_wrap", 32'(bus0.wrap), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // SCAN with last = 5
        bus0.mode = 1'b1;
        bus0.last = 3'd5;
        for (int k = 0; k < 14; k++)
            step0($sformatf("scan5_%0d", k), scan5_idx[k], scan5_idx[k] == 5);

        // Enable gap: fresh scan with last = 7, drop en at idx 3
        bus0.mode = 1'b0;
        bus0.i = 3'd0;
        step0("gap_direct", 0, 1'b0);
        bus0.mode = 1'b1;
        bus0.last = 3'd7;
        for (int k = 0; k < 4; k++)
            step0($sformatf("gap_pre_%0d", k), k, 1'b0);
        bus0.en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("gap_off_d_%0d", k),    32'(bus0.d),    32'h00);
            check($sformatf("gap_off_idx_%0d", k),  32'(bus0.idx),  32'h3);
            check($sformatf("gap_off_wrap_%0d", k), 32'(bus0.wrap), 32'h0);
        end
        bus0.en = 1'b1;
        for (int k = 0; k < 5; k++)
            step0($sformatf("gap_resume_%0d", k), resume_idx[k], resume_wrap[k]);

        // last lowered below the counter mid-scan (mode 1->0->1 restarts at 0)
        bus0.mode = 1'b0;
        step0("lower_direct", 0, 1'b0);
        bus0.mode = 1'b1;
        bus0.last = 3'd7;
        for (int k = 0; k < 7; k++)
            step0($sformatf("lower_pre_%0d", k), k, 1'b0);
        bus0.last = 3'd2;
        step0("lower_7", 7, 1'b1);
        step0("lower_0", 0, 1'b0);
        step0("lower_1", 1, 1'b0);
        step0("lower_2", 2, 1'b1);

        // last = 0: line 0 every cycle with wrap every cycle
        bus0.mode = 1'b0;
        step0("last0_direct", 0, 1'b0);
        bus0.mode = 1'b1;
        bus0.last = 3'd0;
        for (int k = 0; k < 4; k++)
            step0($sformatf("last0_%0d", k), 0, 1'b1);
        bus0.en = 1'b0;

        // Active-low polarity
        bus1.en = 1'b1;
        bus1.mode = 1'b0;
        bus1.i = 3'd6;
        tick();
        check("pol_d_sel",  32'(bus1.d),   32'hBF);
        check("pol_idx",    32'(bus1.idx), 32'h6);
        bus1.en = 1'b0;
        tick();
        check("pol_d_off",  32'(bus1.d),   32'hFF);
        check("pol_idx_hold", 32'(bus1.idx), 32'h6);

        // N = 4 full sweep, last = 15
        bus2.en = 1'b1;
        bus2.mode = 1'b1;
        bus2.last = 4'd15;
        for (int k = 0; k < 17; k++) begin
            int e;
            e = k % 16;
            tick();
            check($sformatf("n4_d_%0d", k),    32'(bus2.d),    32'(16'h0001 << e));
            check($sformatf("n4_idx_%0d", k),  32'(bus2.idx),  32'(e));
            check($sformatf("n4_wrap_%0d", k), 32'(bus2.wrap), 32'(e == 15));
            if (k == 15)
                check("n4_top", 32'(bus2.d), 32'h8000);
        end
        bus2.en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder_seq.md
Name: decoder_seq

Overview:
- Parametrised, registered N-to-2^N one-hot decoder.
- Generalises the combinational 3-to-8 decoder in two ways:
  - output width follows N, with a selectable output polarity;
  - a built-in scan mode walks the active line 0..last and wraps.
- Drives row/segment/chip selects and strobe sequencing in the structural-modelling collection, where a glitch-free registered select is required.

Parameters:
- N, 3, select width; output width is 2^N (N >= 1).
- ACTIVE_LOW, 0, 0 = selected line high, others low; 1 = selected line low, others high.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  enable; when low, outputs are blanked.
- mode  input  1  0 = DIRECT (decode i); 1 = SCAN (decode internal counter).
- i  input  N  select index, used in DIRECT mode.
- last  input  N  highest index visited in SCAN mode.
- d  output  2^N  registered one-hot (or one-cold) decode output.
- idx  output  N  index currently driven on d.
- wrap  output  1  one-cycle pulse; high with the final index (last) of a scan pass.

Behaviour:
- Interface:
  - One clock, clk. Reset rst is asynchronous and active-high.
  - All outputs are registered; no combinational path from any input to any output.
- Polarity: d = onehot(x) XOR {2^N{ACTIVE_LOW}}. "Inactive" means all zeros (ACTIVE_LOW=0) or all ones (ACTIVE_LOW=1).
- Reset (async assert, at any time, including mid-scan):
  - d = inactive, idx = 0, wrap = 0.
  - Internal counter cnt = 0; prev_mode = 0.
  - Reset released: the first active edge behaves as a normal cycle.
- en = 0 at a clock edge:
  - d <= inactive, wrap <= 0.
  - idx, cnt and prev_mode hold.
  - Scan resumes from the held cnt when en returns high.
- DIRECT (en = 1, mode = 0):
  - d <= onehot(i), idx <= i, wrap <= 0. Latency: 1 clock from i to d.
  - cnt <= 0, so a later switch to SCAN starts at 0.
- SCAN (en = 1, mode = 1):
  - Let s = 0 if prev_mode == 0 (scan just entered); otherwise s = cnt.
  - d <= onehot(s), idx <= s.
  - If s == last or s == 2^N-1: cnt <= 0 and wrap <= 1. Otherwise cnt <= s+1 and wrap <= 0.
  - Period of a pass is last+1 cycles.
- prev_mode <= mode on every edge where en = 1.
- Boundary conditions:
  - last = 0: d stays onehot(0); wrap is high every cycle.
  - last = 2^N-1: full sweep with natural counter wrap.
  - last lowered below cnt mid-scan: the counter continues upward to 2^N-1, then wraps to 0 with wrap pulsed. No skip, no lock-up.
  - last raised mid-scan: takes effect immediately on the next comparison.
  - Mode toggled 1->0->1: scan restarts at 0.
- Invariant: while en is high after its first edge, d always has exactly one active bit.

Test Plan:
- Reset values: N=3, ACTIVE_LOW=0. Assert rst mid-cycle -> d = 8'h00, idx = 0, wrap = 0 immediately, without waiting for a clock edge.
- DIRECT sweep: mode = 0, en = 1, i = 0..7, one per cycle -> d = 01, 02, 04 … 80 one cycle after each i; idx tracks i; wrap = 0 throughout.
- SCAN with last = 5: mode = 1, en = 1 for 14 cycles.
  - idx = 0,1,2,3,4,5,0,1,…; d = 01 … 20, repeating.
  - wrap high exactly in the cycles where idx = 5.
- Enable gap: SCAN with last = 7; drop en for 3 cycles when idx = 3.
  - d = 00 during the gap.
  - On re-enable, idx resumes at 4; no extra wrap pulse.
- Polarity: ACTIVE_LOW = 1, DIRECT, i = 6 -> d = 8'hBF. With en = 0 -> d = 8'hFF. Reset -> d = 8'hFF.
- Boundaries:
  - last = 0 -> d = 01 with wrap every cycle.
  - At idx = 6 with last = 7, change last to 2 -> idx = 7 (wrap = 1), then 0, 1, 2 (wrap = 1).
  - N = 4 build, last = 15 -> 16-cycle period, d = 16'h8000 at idx = 15.
